// File: rtl/periph_mmu_pkg.sv
// Shared constants, FSM state type and address-region decode for periph_mmu.
package periph_mmu_pkg;

  localparam logic [31:0] GpioDirAddr = 32'h0000_0100;
  localparam logic [31:0] GpioOutAddr = 32'h0000_0104;
  localparam logic [31:0] GpioInAddr  = 32'h0000_0108;
  localparam logic [31:0] TimerBase   = 32'h0000_0110;
  localparam logic [31:0] StorageBase = 32'h0000_1000;

  typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

  typedef enum logic [2:0] {
    RegRsvd, RegGpioDir, RegGpioOut, RegGpioIn, RegTimer, RegStorage
  } region_e;

  // Region is decoded on the word address; alignment is checked separately.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input int unsigned timer_n);
    logic [31:0] word;
    word = {addr[31:2], 2'b00};
    if (addr >= StorageBase) return RegStorage;
    if (word == GpioDirAddr) return RegGpioDir;
    if (word == GpioOutAddr) return RegGpioOut;
    if (word == GpioInAddr) return RegGpioIn;
    if (word >= TimerBase && word < TimerBase + 32'(4 * timer_n)) return RegTimer;
    return RegRsvd;
  endfunction

endpackage

// File: rtl/periph_mmu_gpio.sv
// GPIO direction/output registers with byte-enable merge, plus a 2-flop input synchronizer.
module periph_mmu_gpio #(
  parameter int unsigned GPIO_N = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dir_we_i,
  input  logic              out_we_i,
  input  logic [3:0]        be_i,
  input  logic [GPIO_N-1:0] wdata_i,
  input  logic [GPIO_N-1:0] gpio_in_i,
  output logic [GPIO_N-1:0] dir_o,
  output logic [GPIO_N-1:0] out_o,
  output logic [GPIO_N-1:0] in_sync_o
);

  logic [GPIO_N-1:0] dir_q, dir_d, out_q, out_d, sync1_q, sync2_q;
  logic              unused_be;

  // Narrow GPIO widths leave the upper byte enables without a lane.
  assign unused_be = ^be_i;

  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    for (int b = 0; b < GPIO_N; b++) begin
      if (dir_we_i && be_i[b/8]) dir_d[b] = wdata_i[b];
      if (out_we_i && be_i[b/8]) out_d[b] = wdata_i[b];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dir_q   <= '0;
      out_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      sync1_q <= gpio_in_i;
      sync2_q <= sync1_q;
    end
  end

  assign dir_o     = dir_q;
  assign out_o     = out_q;
  assign in_sync_o = sync2_q;

endmodule

// File: rtl/periph_mmu.sv
// Core-facing MMU splitting accesses between GPIO, timers and external storage.
// Optional storage watchdog is enabled by defining PERIPH_MMU_TIMEOUT_EN.
module periph_mmu
  import periph_mmu_pkg::*;
#(
  parameter int unsigned MEM_W       = 32,
  parameter int unsigned GPIO_N      = 10,
  parameter int unsigned TIMER_N     = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic [MEM_W/8-1:0] be_i,
  input  logic [MEM_W-1:0]   wdata_i,
  output logic               gnt_o,
  output logic               rvalid_o,
  output logic               err_o,
  output logic [MEM_W-1:0]   rdata_o,
  output logic               st_req_o,
  output logic               st_we_o,
  output logic [31:0]        st_addr_o,
  output logic [MEM_W/8-1:0] st_be_o,
  output logic [MEM_W-1:0]   st_wdata_o,
  input  logic               st_rvalid_i,
  input  logic [MEM_W-1:0]   st_rdata_i,
  input  logic [TIMER_N-1:0] timer_high_i,
  output logic [TIMER_N-1:0] timer_set_o,
  output logic [31:0]        timer_val_o,
  output logic [GPIO_N-1:0]  gpio_oe_o,
  output logic [GPIO_N-1:0]  gpio_out_o,
  input  logic [GPIO_N-1:0]  gpio_in_i
);

  state_e              state_q, state_d;
  logic [31:0]         addr_q;
  logic                we_q;
  logic [MEM_W/8-1:0]  be_q;
  logic [MEM_W-1:0]    wdata_q, st_rdata_q;
  logic                st_err_q;
  region_e             region;
  logic                grant, acc_err, timeout, dir_we, out_we;
  logic [2:0]          tidx;
  logic [31:0]         rd32;
  logic [GPIO_N-1:0]   gpio_dir, gpio_out, gpio_sync;

  // Gate with reset so a request is never acknowledged and then dropped.
  assign grant   = rst && req_i && (state_q == StIdle);
  assign region  = decode_region(addr_q, TIMER_N);
  assign acc_err = (region == RegRsvd) || (region != RegStorage && addr_q[1:0] != 2'b00) ||
                   (region == RegGpioIn && we_q);
  assign tidx    = 3'((addr_q - TimerBase) >> 2);

`ifdef PERIPH_MMU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
  logic [CntW-1:0] cnt_q;

  assign timeout = (state_q == StMem) && (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst)                  cnt_q <= '0;
    else if (grant)            cnt_q <= '0;
    else if (state_q == StMem) cnt_q <= cnt_q + 1'b1;
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_i) state_d = (decode_region(addr_i, TIMER_N) == RegStorage) ? StMem : StResp;
      StMem:  if (st_rvalid_i || timeout) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      st_rdata_q <= '0;
      st_err_q   <= 1'b0;
    end else begin
      if (grant) begin
        addr_q  <= addr_i;
        we_q    <= we_i;
        be_q    <= be_i;
        wdata_q <= wdata_i;
      end
      if (state_q == StMem) begin
        // Storage completion beats a coincident watchdog expiry.
        if (st_rvalid_i) begin
          st_rdata_q <= st_rdata_i;
          st_err_q   <= 1'b0;
        end else if (timeout) begin
          st_rdata_q <= '0;
          st_err_q   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_o       = grant;
    rvalid_o    = 1'b0;
    err_o       = 1'b0;
    rdata_o     = '0;
    rd32        = '0;
    timer_set_o = '0;
    timer_val_o = '0;
    dir_we      = 1'b0;
    out_we      = 1'b0;
    st_req_o    = (state_q == StMem);
    st_we_o     = st_req_o && we_q;
    st_addr_o   = st_req_o ? addr_q : '0;
    st_be_o     = st_req_o ? be_q : '0;
    st_wdata_o  = st_req_o ? wdata_q : '0;
    if (state_q == StResp) begin
      rvalid_o = 1'b1;
      if (region == RegStorage) begin
        err_o   = st_err_q;
        rdata_o = st_rdata_q;
      end else if (acc_err) begin
        err_o = 1'b1;
      end else begin
        unique case (region)
          RegGpioDir: begin
            dir_we = we_q;
            rd32   = 32'(gpio_dir);
          end
          RegGpioOut: begin
            out_we = we_q;
            rd32   = 32'(gpio_out);
          end
          RegGpioIn: rd32 = 32'(gpio_sync);
          RegTimer: begin
            for (int i = 0; i < TIMER_N; i++) begin
              if (tidx == 3'(i)) begin
                if (we_q) begin
                  timer_set_o[i] = 1'b1;
                  timer_val_o    = wdata_q[31:0];
                end else begin
                  rd32 = 32'(timer_high_i[i]);
                end
              end
            end
          end
          default: ;
        endcase
        if (!we_q) rdata_o = MEM_W'(rd32);
      end
    end
  end

  periph_mmu_gpio #(
    .GPIO_N(GPIO_N)
  ) u_gpio (
    .clk      (clk),
    .rst      (rst),
    .dir_we_i (dir_we),
    .out_we_i (out_we),
    .be_i     (be_q[3:0]),
    .wdata_i  (wdata_q[GPIO_N-1:0]),
    .gpio_in_i(gpio_in_i),
    .dir_o    (gpio_dir),
    .out_o    (gpio_out),
    .in_sync_o(gpio_sync)
  );

  assign gpio_oe_o  = gpio_dir;
  assign gpio_out_o = gpio_out & gpio_dir;

endmodule

// File: doc/periph_mmu.md
PERIPH_MMU -- requirements
Module: periph_mmu

Interface
REQ-001 Parameter MEM_W, default 32: data bus width in bits; SHALL be a multiple of 32 and at least 32.
REQ-002 Parameter GPIO_N, default 10: number of GPIO pins, range 1..32.
REQ-003 Parameter TIMER_N, default 2: number of timer channels, range 1..8.
REQ-004 Parameter TIMEOUT_CYC, default 1024: storage watchdog limit in cycles, minimum 2.
REQ-005 Reset is rst, synchronous, active-low; clock is clk.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- req_i  in  1  core request.
- addr_i  in  32  byte address.
- we_i  in  1  1 = write.
- be_i  in  MEM_W/8  byte enables.
- wdata_i  in  MEM_W  write data.
- gnt_o  out  1  request accepted.
- rvalid_o  out  1  response valid (reads and writes).
- err_o  out  1  response is an error; valid only with rvalid_o.
- rdata_o  out  MEM_W  read data.
- st_req_o  out  1  storage request.
- st_we_o  out  1  storage write.
- st_addr_o  out  32  storage address.
- st_be_o  out  MEM_W/8  storage byte enables.
- st_wdata_o  out  MEM_W  storage write data.
- st_rvalid_i  in  1  storage done.
- st_rdata_i  in  MEM_W  storage read data.
- timer_high_i  in  TIMER_N  timer expired flags.
- timer_set_o  out  TIMER_N  one-cycle load strobe per channel.
- timer_val_o  out  32  load value.
- gpio_oe_o  out  GPIO_N  pin output enable.
- gpio_out_o  out  GPIO_N  pin drive value.
- gpio_in_i  in  GPIO_N  asynchronous pin input.

Function
REQ-007 Address map (word-aligned):
- 0x000-0x0FF: reserved.
- 0x100: GPIO_DIR, R/W, 1 = output.
- 0x104: GPIO_OUT, R/W.
- 0x108: GPIO_IN, read-only.
- 0x110 + 4*i: timer i.
- 0x10C, 0x110 + 4*TIMER_N through 0xFFF: reserved.
- >= 0x1000: storage.
REQ-008 FSM states SHALL be IDLE, MEM and RESP.
REQ-009 gnt_o SHALL equal req_i while in IDLE, and 0 in all other states.
REQ-010 On grant, addr_i, we_i, be_i and wdata_i SHALL be captured.
REQ-011 A granted peripheral or reserved access SHALL go to RESP; a granted storage access SHALL go to MEM.
REQ-012 RESP SHALL assert rvalid_o for exactly one cycle, then return to IDLE. A peripheral access therefore responds on the cycle after grant, and the minimum spacing between grants is 2 cycles.
REQ-013 The following SHALL respond with err_o=1 and rdata_o=0, with no side effects:
- a reserved address;
- a peripheral address with addr[1:0] != 0;
- a write to GPIO_IN.
REQ-014 GPIO register writes SHALL honour byte enables: be[k] gates bits 8k+7:8k. Bits at or above GPIO_N SHALL be ignored on write and read as 0.
REQ-015 GPIO_IN SHALL return gpio_in_i after a 2-flop synchronizer.
REQ-016 gpio_oe_o SHALL equal GPIO_DIR, and gpio_out_o SHALL equal GPIO_OUT & GPIO_DIR.
REQ-017 A timer i write SHALL, in its RESP cycle, pulse timer_set_o[i] and drive timer_val_o with wdata[31:0]. At all other times timer_val_o SHALL be 0.
REQ-018 A timer i read SHALL return {31'b0, timer_high_i[i]}, sampled in RESP.
REQ-019 In MEM, st_req_o SHALL be held high with the captured fields until st_rvalid_i=1. The following cycle SHALL be RESP, carrying st_rdata_i (registered) and err_o=0.
REQ-020 If st_rvalid_i arrives in the same cycle as a watchdog expiry, st_rvalid_i SHALL win.
REQ-021 For reads, rdata_o SHALL carry the data in bits 31:0 with the upper bits 0, except for storage reads, which return full width.

Reset
REQ-022 Reset SHALL force all of the following to 0:
- state (IDLE) and all captured fields;
- GPIO_DIR, GPIO_OUT and the synchronizer flops;
- all outputs.
REQ-023 Reset asserted in MEM SHALL drop st_req_o at that edge, and no response SHALL be issued.

Configuration
REQ-024 With PERIPH_MMU_TIMEOUT_EN defined:
- a counter cleared on MEM entry SHALL count cycles in MEM;
- on reaching TIMEOUT_CYC it SHALL deassert st_req_o and go to RESP with err_o=1;
- late st_rvalid_i in IDLE SHALL be ignored.
REQ-025 Without PERIPH_MMU_TIMEOUT_EN, no counter SHALL exist and MEM SHALL wait indefinitely.

Structure
REQ-026 Package periph_mmu_pkg SHALL hold:
- the address constants;
- the state enum;
- a region-decode function.
REQ-027 Sub-module periph_mmu_gpio SHALL hold the GPIO_DIR and GPIO_OUT registers, the byte-enable merge and the synchronizer.

Verification
REQ-028 Write 0x3 to 0x100, then write 0x1 to 0x104 -> each acknowledged with rvalid one cycle after gnt and err=0; gpio_oe_o=0x003, gpio_out_o=0x001.
REQ-029 Set gpio_in_i=0x2A5, then read 0x108 -> rdata=0x2A5, provided 2 cycles elapse before grant; write to 0x108 -> err=1.
REQ-030 Write 0x0000_0500 to 0x114 -> timer_set_o=0b10 and timer_val_o=0x500 for exactly one cycle; read 0x114 with timer_high_i=0b10 -> rdata=1.
REQ-031 Read 0x1000 with storage responding after 5 cycles with 0xDEADBEEF -> st_req_o high for 5 cycles, then rvalid with rdata=0xDEADBEEF.
REQ-032 Read 0x0040, read 0x102, and read 0x110+4*TIMER_N -> err=1 on each; no storage or peripheral side effect.
REQ-033 With PERIPH_MMU_TIMEOUT_EN and TIMEOUT_CYC=16, storage silent -> err=1 after 16 MEM cycles. Separately, rst low mid-MEM -> st_req_o=0 next cycle and no rvalid.
